fault_campaign_ctrl: RTL and testbench
======================================

FAULT_CAMPAIGN_CTRL -- requirements
Module: fault_campaign_ctrl

Interface
REQ-001 SHALL have parameter NUM_SITES, default 16, number of fault sites, numbered 1..NUM_SITES (sel 0 = fault-free).
REQ-002 SHALL have parameter SETTLE, default 1, extra cycles held before sampling observed outputs (0..7).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin campaign; honoured only in IDLE.
- abort  in  1  terminate campaign.
- sel  out  5  fault-site select to injection wrapper.
- control  out  1  stuck-at value to injection wrapper.
- vec  out  4  test vector {a,b,c,e}, vec[3]=a.
- y_obs  in  1  observed y from wrapper.
- z_obs  in  1  observed z from wrapper.
- busy  out  1  campaign in progress.
- done  out  1  one-cycle pulse, campaign completed normally.
- det_valid  out  1  one-cycle pulse, fault verdict available.
- det_site  out  5  site of reported fault.
- det_sa  out  1  stuck-at value of reported fault.
- det_vec  out  4  detecting vector (0 when undetected).
- detected  out  1  1 = fault detected, 0 = undetectable by all 16 vectors.
- cov_cnt  out  6  count of detected faults in current or last campaign.

Function
REQ-004 SHALL iterate faults in order site 1..NUM_SITES (outer), stuck-at 0 then 1 (inner); 2*NUM_SITES faults total.
REQ-005 SHALL, per fault, iterate vec 0..15 ascending, restarting at 0 for each fault.
REQ-006 SHALL use states IDLE, GOLD, FAULT, CMP, REPORT, FINISH.
REQ-007 IDLE: sel=0, control=0, vec=0, busy=0; start=1 -> GOLD with site=1, sa=0, vec=0, cov_cnt cleared to 0.
REQ-008 GOLD: sel=0, vec driven; lasts SETTLE+1 cycles; y_obs/z_obs captured as golden on last cycle; -> FAULT.
REQ-009 FAULT: sel=site, control=sa, same vec; lasts SETTLE+1 cycles; outputs captured on last cycle; -> CMP.
REQ-010 CMP (1 cycle, sel=0): mismatch on y or z -> REPORT detected=1, det_vec=vec; match and vec<15 -> GOLD with vec+1; match and vec=15 -> REPORT detected=0, det_vec=0.
REQ-011 Fault dropping: after a detection no further vectors SHALL be applied for that fault.
REQ-012 REPORT (1 cycle): det_valid=1 with det_site, det_sa, det_vec, detected stable that cycle; cov_cnt increments by 1 on the same edge if detected=1; -> next fault GOLD, or FINISH after site NUM_SITES sa 1.
REQ-013 FINISH (1 cycle): done=1, busy=0 -> IDLE; cov_cnt held until next start.
REQ-014 busy SHALL be 1 in GOLD, FAULT, CMP, REPORT.
REQ-015 start while busy SHALL be ignored.
REQ-016 abort=1 in any busy state SHALL force IDLE on next edge; no done, no det_valid; cov_cnt holds partial count; abort has priority over all transitions.
REQ-017 Counter wrap: site and vec counters SHALL NOT wrap; end-of-range detected explicitly per REQ-010/REQ-012.
REQ-018 Cycles per applied vector SHALL be 2*(SETTLE+1)+1.

Reset
REQ-019 rst_n=0 SHALL asynchronously force IDLE, sel=0, control=0, vec=0, busy=0, done=0, det_valid=0, det_site=0, det_sa=0, det_vec=0, detected=0, cov_cnt=0, including mid-campaign.
REQ-020 After rst_n deassertion the block SHALL remain IDLE until start.

Verification
REQ-021 Bench stub y_obs=a^b, z_obs=c&e except sel=1 forces a=control; SETTLE=1, NUM_SITES=1, start -> site1 sa0 detected at vec 8 (5 cycles/vector), sa1 detected at vec 0, cov_cnt=2, done one cycle after second det_valid.
REQ-022 Stub ignoring sel, NUM_SITES=2 -> four det_valid with detected=0, det_vec=0, each after 16 vectors; cov_cnt=0; done pulses.
REQ-023 abort asserted during FAULT of site 1 sa 1 -> IDLE next cycle, busy=0, no done, cov_cnt=1.
REQ-024 rst_n low mid-GOLD -> all outputs zero immediately, IDLE after release; start pulse in IDLE begins cleanly from site 1.
REQ-025 start held high throughout campaign -> no restart before FINISH; new campaign begins in cycle after FINISH returns to IDLE.
REQ-026 Default parameters, stub detecting every fault at vec 0 -> 32 det_valid pulses, cov_cnt=32, campaign length 32*(5+1)+1 cycles after start.

Source files
------------

// File: rtl/fault_campaign_ctrl_if.sv
// Bundle between the fault-campaign controller, its injection wrapper and its campaign host.
// The controller takes the master side.
interface fault_campaign_ctrl_if;
  localparam int unsigned SITE_W = 5;
  localparam int unsigned VEC_W  = 4;
  localparam int unsigned COV_W  = 6;

  logic              start;
  logic              abort;
  logic [SITE_W-1:0] sel;
  logic              control;
  logic [VEC_W-1:0]  vec;
  logic              y_obs;
  logic              z_obs;
  logic              busy;
  logic              done;
  logic              det_valid;
  logic [SITE_W-1:0] det_site;
  logic              det_sa;
  logic [VEC_W-1:0]  det_vec;
  logic              detected;
  logic [COV_W-1:0]  cov_cnt;

  modport master (
    input  start, abort, y_obs, z_obs,
    output sel, control, vec, busy, done, det_valid,
           det_site, det_sa, det_vec, detected, cov_cnt
  );

  modport slave (
    output start, abort, y_obs, z_obs,
    input  sel, control, vec, busy, done, det_valid,
           det_site, det_sa, det_vec, detected, cov_cnt
  );
endinterface

// File: rtl/fault_campaign_ctrl.sv
// Stuck-at fault campaign sequencer: for each site/polarity it applies vectors golden-then-faulty,
// compares the captured outputs, drops the fault on its first detection and reports a verdict.
module fault_campaign_ctrl #(
  parameter int unsigned NUM_SITES = 16,
  parameter int unsigned SETTLE    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fault_campaign_ctrl_if.master bus
);
  localparam int unsigned SITE_W = 5;
  localparam int unsigned VEC_W  = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned COV_W  = 6;

  typedef enum logic [2:0] {IDLE, GOLD, FAULT, CMP, REPORT, FINISH} state_e;

  state_e            state_q, state_d;
  logic [SITE_W-1:0] site_q, site_d;
  logic              sa_q, sa_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gold_y_q, gold_y_d, gold_z_q, gold_z_d;
  logic              flt_y_q, flt_y_d, flt_z_q, flt_z_d;
  logic [SITE_W-1:0] sel_q, sel_d;
  logic              control_q, control_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              det_valid_q, det_valid_d;
  logic [SITE_W-1:0] det_site_q, det_site_d;
  logic              det_sa_q, det_sa_d;
  logic [VEC_W-1:0]  det_vec_q, det_vec_d;
  logic              detected_q, detected_d;
  logic [COV_W-1:0]  cov_q, cov_d;
  logic              last_c;

  assign last_c = (cnt_q == CNT_W'(SETTLE));

  // Next state plus next values of every registered output (outputs follow state_d).
  always_comb begin
    state_d    = state_q;
    site_d     = site_q;
    sa_d       = sa_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    gold_y_d   = gold_y_q;
    gold_z_d   = gold_z_q;
    flt_y_d    = flt_y_q;
    flt_z_d    = flt_z_q;
    det_site_d = det_site_q;
    det_sa_d   = det_sa_q;
    det_vec_d  = det_vec_q;
    detected_d = detected_q;
    cov_d      = cov_q;

    if (bus.abort && busy_q) begin
      state_d = IDLE;
      vec_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = GOLD;
            site_d  = SITE_W'(1);
            sa_d    = 1'b0;
            vec_d   = '0;
            cnt_d   = '0;
            cov_d   = '0;
          end
        end
        GOLD: begin
          if (last_c) begin
            gold_y_d = bus.y_obs;
            gold_z_d = bus.z_obs;
            cnt_d    = '0;
            state_d  = FAULT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FAULT: begin
          if (last_c) begin
            flt_y_d = bus.y_obs;
            flt_z_d = bus.z_obs;
            cnt_d   = '0;
            state_d = CMP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CMP: begin
          if ((gold_y_q != flt_y_q) || (gold_z_q != flt_z_q)) begin
            state_d    = REPORT;
            det_site_d = site_q;
            det_sa_d   = sa_q;
            det_vec_d  = vec_q;
            detected_d = 1'b1;
            cov_d      = cov_q + COV_W'(1);
          end else if (vec_q == '1) begin
            state_d    = REPORT;
            det_site_d = site_q;
            det_sa_d   = sa_q;
            det_vec_d  = '0;
            detected_d = 1'b0;
          end else begin
            vec_d   = vec_q + VEC_W'(1);
            state_d = GOLD;
          end
        end
        REPORT: begin
          vec_d = '0;
          if (sa_q && (site_q == SITE_W'(NUM_SITES))) begin
            state_d = FINISH;
          end else begin
            state_d = GOLD;
            sa_d    = ~sa_q;
            if (sa_q) site_d = site_q + SITE_W'(1);
          end
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    sel_d       = (state_d == FAULT) ? site_d : '0;
    control_d   = (state_d == FAULT) ? sa_d : 1'b0;
    busy_d      = (state_d == GOLD) || (state_d == FAULT) ||
                  (state_d == CMP)  || (state_d == REPORT);
    done_d      = (state_d == FINISH);
    det_valid_d = (state_d == REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      site_q      <= '0;
      sa_q        <= 1'b0;
      vec_q       <= '0;
      cnt_q       <= '0;
      gold_y_q    <= 1'b0;
      gold_z_q    <= 1'b0;
      flt_y_q     <= 1'b0;
      flt_z_q     <= 1'b0;
      sel_q       <= '0;
      control_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      det_valid_q <= 1'b0;
      det_site_q  <= '0;
      det_sa_q    <= 1'b0;
      det_vec_q   <= '0;
      detected_q  <= 1'b0;
      cov_q       <= '0;
    end else begin
      state_q     <= state_d;
      site_q      <= site_d;
      sa_q        <= sa_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      gold_y_q    <= gold_y_d;
      gold_z_q    <= gold_z_d;
      flt_y_q     <= flt_y_d;
      flt_z_q     <= flt_z_d;
      sel_q       <= sel_d;
      control_q   <= control_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      det_valid_q <= det_valid_d;
      det_site_q  <= det_site_d;
      det_sa_q    <= det_sa_d;
      det_vec_q   <= det_vec_d;
      detected_q  <= detected_d;
      cov_q       <= cov_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.control   = control_q;
  assign bus.vec       = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.det_valid = det_valid_q;
  assign bus.det_site  = det_site_q;
  assign bus.det_sa    = det_sa_q;
  assign bus.det_vec   = det_vec_q;
  assign bus.detected  = detected_q;
  assign bus.cov_cnt   = cov_q;
endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Campaign bench: a randomly faulted circuit stub with SETTLE-cycle output latency,
// and a per-fault first-detecting-vector reference model.
module tb_fault_campaign_ctrl;
  localparam int unsigned NS  = 16;
  localparam int unsigned ST  = 1;
  localparam int unsigned CPV = 2 * (ST + 1) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fault_campaign_ctrl_if bus ();

  fault_campaign_ctrl #(.NUM_SITES(NS), .SETTLE(ST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fault effect per site: 0..3 stick a/b/c/e, 4 sticks y, 5 sticks z, 6/7 inert, 8 inverts y.
  int node_map [1:NS];

  function automatic logic [1:0] stub(input logic [4:0] s, input logic ctl, input logic [3:0] v);
    logic a, b, c, e, y, z;
    int n;
    a = v[3]; b = v[2]; c = v[1]; e = v[0];
    n = 6;
    if (s != 5'd0 && int'(s) <= NS) n = node_map[int'(s)];
    case (n)
      0: a = ctl;
      1: b = ctl;
      2: c = ctl;
      3: e = ctl;
      default: ;
    endcase
    y = a ^ b;
    z = c & e;
    if (n == 4) y = ctl;
    if (n == 5) z = ctl;
    if (n == 8) y = ~y;
    return {y, z};
  endfunction

  logic [1:0] dly [0:ST-1];
  always @(posedge clk) begin
    dly[0] <= stub(bus.sel, bus.control, bus.vec);
    for (int i = 1; i < int'(ST); i++) dly[i] <= dly[i-1];
  end
  assign bus.y_obs = dly[ST-1][1];
  assign bus.z_obs = dly[ST-1][0];

  typedef struct {
    int site;
    int sa;
    int vec;
    int det;
  } rep_t;

  rep_t exp_q[$];
  int   exp_cov;
  int   exp_len;

  task automatic build_model();
    rep_t r;
    int nv;
    exp_q.delete();
    exp_cov = 0;
    exp_len = 0;
    for (int s = 1; s <= int'(NS); s++) begin
      for (int sa = 0; sa < 2; sa++) begin
        r.site = s; r.sa = sa; r.vec = 0; r.det = 0;
        nv = 16;
        for (int v = 0; v < 16; v++) begin
          if (stub(5'd0, 1'b0, 4'(v)) != stub(5'(s), 1'(sa), 4'(v))) begin
            r.vec = v; r.det = 1; nv = v + 1;
            break;
          end
        end
        exp_cov += r.det;
        exp_len += nv * int'(CPV) + 1;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic randomize_map();
    for (int i = 1; i <= int'(NS); i++) node_map[i] = int'($urandom_range(0, 8));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_sel"}, bus.sel, 0);
    chk({tag, "_control"}, bus.control, 0);
    chk({tag, "_vec"}, bus.vec, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_det_valid"}, bus.det_valid, 0);
    chk({tag, "_det_site"}, bus.det_site, 0);
    chk({tag, "_det_sa"}, bus.det_sa, 0);
    chk({tag, "_det_vec"}, bus.det_vec, 0);
    chk({tag, "_detected"}, bus.detected, 0);
    chk({tag, "_cov_cnt"}, bus.cov_cnt, 0);
  endtask

  task automatic run_campaign(input bit hold_start);
    rep_t r;
    int k, ndet;
    bit seen_done;
    build_model();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk);
    if (!hold_start) bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    chk("cov_cleared", bus.cov_cnt, 0);
    k = 0; ndet = 0; seen_done = 0;
    while (!seen_done && k <= exp_len + 8) begin
      if (bus.det_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_det_valid", bus.det_valid, 0);
        end else begin
          r = exp_q.pop_front();
          chk("det_site", bus.det_site, r.site);
          chk("det_sa", bus.det_sa, r.sa);
          chk("det_vec", bus.det_vec, r.vec);
          chk("detected", bus.detected, r.det);
          ndet += r.det;
          chk("cov_cnt_running", bus.cov_cnt, ndet);
        end
      end
      if (bus.done) begin
        seen_done = 1;
        chk("done_cycle", k, exp_len);
        chk("busy_at_done", bus.busy, 0);
        chk("cov_final", bus.cov_cnt, exp_cov);
        chk("reports_left", exp_q.size(), 0);
      end else begin
        chk("busy_in_campaign", bus.busy, 1);
        @(negedge clk);
        k++;
      end
    end
    if (!seen_done) chk("done_timeout", seen_done, 1);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("idle_after_finish", bus.busy, 0);
    chk("cov_held", bus.cov_cnt, exp_cov);
    if (hold_start) begin
      @(negedge clk);
      chk("restart_after_idle", bus.busy, 1);
      chk("restart_cov_cleared", bus.cov_cnt, 0);
      bus.start = 1'b0;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_restart_idle", bus.busy, 0);
    end
  endtask

  task automatic abort_test();
    int k;
    randomize_map();
    node_map[1] = 0;
    build_model();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    k = 0;
    while (!(bus.sel == 5'd1 && bus.control == 1'b1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("reach_site1_sa1", {31'b0, bus.sel == 5'd1 && bus.control == 1'b1}, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_sel", bus.sel, 0);
    chk("abort_vec", bus.vec, 0);
    chk("abort_cov", bus.cov_cnt, exp_q[0].det);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", bus.done, 0);
      chk("abort_no_det", bus.det_valid, 0);
      chk("abort_stay_idle", bus.busy, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    randomize_map();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_until_start", bus.busy, 0);
    end

    randomize_map();
    run_campaign(1'b0);

    for (int i = 1; i <= int'(NS); i++) node_map[i] = 8;
    run_campaign(1'b0);

    for (int i = 1; i <= int'(NS); i++) node_map[i] = 6;
    run_campaign(1'b1);

    abort_test();

    randomize_map();
    run_campaign(1'b0);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_after_reset", bus.busy, 0);
    end

    for (int c = 0; c < 3; c++) begin
      randomize_map();
      run_campaign(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
